// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter: prescaled up/down BCD counter (clear, load, wrap_o, tick_o) with a multiplexed 7-segment scan (seg_o, dig_sel_o)
module bcd_scan_counter #(
    parameter int NUM_DIGITS = 2,
    parameter int COUNT_DIV_LOG2 = 20,
    parameter int SCAN_DIV_LOG2 = 14,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic                    up_i,
    input  logic                    clear_i,
    input  logic                    load_i,
    input  logic [4*NUM_DIGITS-1:0] load_value_i,
    output logic [4*NUM_DIGITS-1:0] count_o,
    output logic                    wrap_o,
    output logic                    tick_o,
    output logic [6:0]              seg_o,
    output logic [NUM_DIGITS-1:0]   dig_sel_o
);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    logic [NUM_DIGITS-1:0][3:0] cnt, nxt, ldv;
    logic [NUM_DIGITS-1:0]      blank;
    logic [COUNT_DIV_LOG2-1:0]  cpre;
    logic [SCAN_DIV_LOG2-1:0]   spre;
    logic [IW-1:0]              idx;
    logic                       carry, hz;
    logic [6:0]                 seg_raw;
    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0: decode = 7'h3F;
            4'd1: decode = 7'h06;
            4'd2: decode = 7'h5B;
            4'd3: decode = 7'h4F;
            4'd4: decode = 7'h66;
            4'd5: decode = 7'h6D;
            4'd6: decode = 7'h7D;
            4'd7: decode = 7'h07;
            4'd8: decode = 7'h7F;
            4'd9: decode = 7'h6F;
            default: decode = 7'h00;
        endcase
    endfunction
    assign count_o = cnt;
    assign tick_o = &cpre;
    always_comb begin
        nxt = cnt;
        ldv = '0;
        blank = '0;
        carry = 1'b1;
        hz = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            ldv[i] = load_value_i[4*i +: 4] > 4'd9 ? 4'd9 : load_value_i[4*i +: 4];
            if (carry)
                nxt[i] = up_i ? (cnt[i] == 4'd9 ? 4'd0 : cnt[i] + 4'd1)
                              : (cnt[i] == 4'd0 ? 4'd9 : cnt[i] - 4'd1);
            carry = carry & (up_i ? cnt[i] == 4'd9 : cnt[i] == 4'd0);
        end
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            hz = hz & (cnt[i] == 4'd0);
            blank[i] = BLANK_LEADING && i != 0 && hz;
        end
        seg_raw = blank[idx] ? 7'h00 : decode(cnt[idx]);
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt <= '0;
            wrap_o <= 1'b0;
            cpre <= '0;
            spre <= '0;
            idx <= '0;
            dig_sel_o <= '0;
            seg_o <= SEG_OFF;
        end else begin
            cpre <= cpre + 1'b1;
            spre <= spre + 1'b1;
            wrap_o <= 1'b0;
            if (clear_i)
                cnt <= '0;
            else if (load_i)
                cnt <= ldv;
            else if (tick_o && en_i) begin
                cnt <= nxt;
                wrap_o <= carry;
            end
            if (&spre)
                idx <= idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
            dig_sel_o <= NUM_DIGITS'(1) << idx;
            seg_o <= seg_raw ^ {7{SEG_ACTIVE_LOW}};
        end
    end
endmodule

// File: tb/tb_bcd_scan_counter.sv
// tb_bcd_scan_counter: scoreboard bench comparing two counter variants against an integer reference model
module tb_bcd_scan_counter;
    localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    logic clk = 1'b0, rst = 1'b1, en = 1'b0, up = 1'b1, clr = 1'b0, ld = 1'b0;
    logic [7:0] lv = 8'h00;
    logic [7:0] cnt_a, cnt_b;
    logic wrap_a, wrap_b, tick_a, tick_b;
    logic [6:0] seg_a, seg_b;
    logic [1:0] dig_a, dig_b;
    typedef struct {
        logic [7:0] cnt;
        logic       wrap;
        logic       tick;
        logic [6:0] sa;
        logic [6:0] sb;
        logic [1:0] dg;
    } exp_t;
    exp_t q[$];
    exp_t me;
    int checks = 0, passes = 0;
    int val = 0, cyc = 0, idx = 0;
    always #5 clk = ~clk;
    bcd_scan_counter #(.NUM_DIGITS(2), .COUNT_DIV_LOG2(2), .SCAN_DIV_LOG2(1),
                       .SEG_ACTIVE_LOW(1'b0), .BLANK_LEADING(1'b1)) dut_a (
        .clk_i(clk), .rst_i(rst), .en_i(en), .up_i(up), .clear_i(clr), .load_i(ld),
        .load_value_i(lv), .count_o(cnt_a), .wrap_o(wrap_a), .tick_o(tick_a),
        .seg_o(seg_a), .dig_sel_o(dig_a));
    bcd_scan_counter #(.NUM_DIGITS(2), .COUNT_DIV_LOG2(2), .SCAN_DIV_LOG2(1),
                       .SEG_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b0)) dut_b (
        .clk_i(clk), .rst_i(rst), .en_i(en), .up_i(up), .clear_i(clr), .load_i(ld),
        .load_value_i(lv), .count_o(cnt_b), .wrap_o(wrap_b), .tick_o(tick_b),
        .seg_o(seg_b), .dig_sel_o(dig_b));
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a === e) passes++;
        else $display("FAIL %s: got %0h expected %0h", n, a, e);
    endtask
    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10 % 10), 4'(v % 10)};
    endfunction
    function automatic int clamp9(input logic [3:0] d);
        return d > 4'd9 ? 9 : int'(d);
    endfunction
    // Sets inputs for the next edge, predicts the outputs after it, then waits one cycle.
    task automatic drive(input logic c, input logic l, input logic [7:0] v, input logic e, input logic u);
        exp_t x;
        int p, d;
        bit tick, blank;
        clr = c; ld = l; lv = v; en = e; up = u;
        tick = (cyc % 4 == 3);
        p = (idx == 0) ? 1 : 10;
        d = val / p % 10;
        blank = idx != 0 && val < p;
        x.dg = (idx == 0) ? 2'b01 : 2'b10;
        x.sa = blank ? 7'h00 : SEG_TAB[d];
        x.sb = ~SEG_TAB[d];
        x.wrap = 1'b0;
        if (c) val = 0;
        else if (l) val = clamp9(v[7:4]) * 10 + clamp9(v[3:0]);
        else if (tick && e) begin
            x.wrap = u ? (val == 99) : (val == 0);
            val = u ? (val + 1) % 100 : (val + 99) % 100;
        end
        if (cyc % 2 == 1) idx = (idx + 1) % 2;
        cyc++;
        x.cnt = to_bcd(val);
        x.tick = (cyc % 4 == 3);
        q.push_back(x);
        @(negedge clk);
    endtask
    task automatic check_reset(input string n);
        chk({n, " cnt_a"}, cnt_a, 0);
        chk({n, " cnt_b"}, cnt_b, 0);
        chk({n, " wrap"}, {wrap_a, wrap_b}, 0);
        chk({n, " tick"}, {tick_a, tick_b}, 0);
        chk({n, " seg_a"}, seg_a, 7'h00);
        chk({n, " seg_b"}, seg_b, 7'h7F);
        chk({n, " dig"}, {dig_a, dig_b}, 0);
    endtask
    task automatic async_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check_reset("async_rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        val = 0; cyc = 0; idx = 0;
    endtask
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            me = q.pop_front();
            chk("count_a", cnt_a, me.cnt);
            chk("count_b", cnt_b, me.cnt);
            chk("wrap", {wrap_a, wrap_b}, {me.wrap, me.wrap});
            chk("tick", {tick_a, tick_b}, {me.tick, me.tick});
            chk("seg_a", seg_a, me.sa);
            chk("seg_b", seg_b, me.sb);
            chk("dig_sel", {dig_a, dig_b}, {me.dg, me.dg});
        end
    end
    initial begin
        @(negedge clk);
        @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        repeat (45) drive(0, 0, 8'h00, 1, 1);
        drive(0, 1, 8'h98, 1, 1);
        repeat (10) drive(0, 0, 8'h00, 1, 1);
        drive(0, 1, 8'h00, 1, 0);
        repeat (10) drive(0, 0, 8'h00, 1, 0);
        drive(0, 1, 8'hA3, 0, 1);
        repeat (3) drive(0, 0, 8'h00, 0, 1);
        drive(1, 1, 8'h55, 1, 1);
        repeat (10) drive(0, 0, 8'h00, 0, 1);
        drive(0, 1, 8'h07, 0, 1);
        repeat (16) drive(0, 0, 8'h00, 0, 1);
        drive(0, 1, 8'h45, 0, 1);
        repeat (3) drive(0, 0, 8'h00, 0, 1);
        async_reset();
        repeat (45) drive(0, 0, 8'h00, 1, 1);
        for (int i = 0; i < 2000; i++)
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0, 8'($urandom),
                  $urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1);
        async_reset();
        repeat (20) drive(0, 0, 8'h00, 1, 0);
        @(posedge clk);
        #3;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
